simd_exec_ctrl: RTL and testbench

Host-bus front end and execution sequencer for the SIMD vector datapath. Decodes Pico parallel-bus writes (CS/WR/CD) into operand-bank, mode and length writes. On an excute pulse it steps the ALU through every element, storing results into the result RAM. Afterwards it serves RD strobes as a byte stream of 16-bit results plus a status byte.

---
 rtl/simd_exec_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_simd_exec_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_exec_ctrl.sv
// Host parallel-bus decoder plus per-element ALU sequencer; strobes act 3 clk after the pin edge.
// Each element costs at least 4 clk; host writes are dropped while busy and data reads return 0x80.
module simd_exec_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CS,
    input  logic              WR,
    input  logic              RD,
    input  logic              CD,
    input  logic              excute,
    input  logic [7:0]        bus_din,
    output logic [7:0]        bus_dout,
    output logic              op_we_a,
    output logic              op_we_b,
    output logic [ADDR_W-1:0] op_waddr,
    output logic [7:0]        op_wdata,
    output logic [ADDR_W-1:0] op_raddr,
    output logic [1:0]        alu_mode,
    output logic              alu_start,
    output logic              alu_clr,
    input  logic              alu_done,
    input  logic [15:0]       alu_result,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_waddr,
    output logic [15:0]       res_wdata,
    output logic [ADDR_W-1:0] res_raddr,
    input  logic [15:0]       res_rdata,
    output logic              busy,
    output logic              done
);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);
    localparam int PW = ADDR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_STORE, S_FIN} state_t;
    state_t state, state_nxt;

    logic [2:0]        wr_sync, rd_sync, ex_sync;
    logic              wr_edge, rd_edge, ex_edge, start, timeout;
    logic [7:0]        addr;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] len, last_idx, idx;
    logic [TW-1:0]     timer;
    logic              err;
    logic [15:0]       res_q;
    logic [PW-1:0]     rptr, last_byte;
    logic              rd_sel, rd_p1, rd_p2;

    // [0],[1] are the synchronizer flops, [2] holds the previous value for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync <= '0;
            rd_sync <= '0;
            ex_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[1:0], WR};
            rd_sync <= {rd_sync[1:0], RD};
            ex_sync <= {ex_sync[1:0], excute};
        end
    end

    assign wr_edge   = wr_sync[1] & ~wr_sync[2];
    assign rd_edge   = rd_sync[1] & ~rd_sync[2];
    assign ex_edge   = ex_sync[1] & ~ex_sync[2];
    assign start     = (state == S_IDLE) && ex_edge;
    assign timeout   = (timer == TW'(ALU_TIMEOUT - 1));
    // len==0 wraps to all-ones, giving the full bank without a special case
    assign last_idx  = len - ADDR_W'(1);
    assign last_byte = {last_idx, 1'b1};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ex_edge) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (alu_done)     state_nxt = S_STORE;
                else if (timeout) state_nxt = S_FIN;
            end
            S_STORE: state_nxt = (idx == last_idx) ? S_FIN : S_FETCH;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            timer <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (ex_edge) begin
                        busy <= 1'b1;
                        done <= 1'b0;
                        err  <= 1'b0;
                        idx  <= '0;
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    if (alu_done)     res_q <= alu_result;
                    else if (timeout) err   <= 1'b1;
                    else              timer <= timer + TW'(1);
                end
                S_STORE: if (idx != last_idx) idx <= idx + ADDR_W'(1);
                S_FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            mode      <= '0;
            len       <= '0;
            op_we_a   <= 1'b0;
            op_we_b   <= 1'b0;
            op_waddr  <= '0;
            op_wdata  <= '0;
            rptr      <= '0;
            rd_sel    <= 1'b0;
            rd_p1     <= 1'b0;
            rd_p2     <= 1'b0;
            res_raddr <= '0;
            bus_dout  <= '0;
        end else begin
            op_we_a <= 1'b0;
            op_we_b <= 1'b0;
            rd_p1   <= 1'b0;
            rd_p2   <= rd_p1;
            if (wr_edge && CS && !busy) begin
                if (CD) begin
                    addr <= bus_din;
                end else if (addr[7:6] == 2'b00) begin
                    op_we_a  <= ~addr[5];
                    op_we_b  <= addr[5];
                    op_waddr <= addr[ADDR_W-1:0];
                    op_wdata <= bus_din;
                    addr[ADDR_W-1:0] <= addr[ADDR_W-1:0] + ADDR_W'(1);
                end else if (addr == 8'd64) begin
                    mode <= bus_din[1:0];
                end else if (addr == 8'd65) begin
                    len <= bus_din[ADDR_W-1:0];
                end
            end
            if (rd_edge && CS) begin
                if (CD) begin
                    bus_dout <= {busy, done, err, 5'b0};
                end else if (busy) begin
                    bus_dout <= 8'h80;
                end else begin
                    rd_p1     <= 1'b1;
                    rd_sel    <= rptr[0];
                    res_raddr <= rptr[PW-1:1];
                    rptr      <= (rptr == last_byte) ? '0 : rptr + PW'(1);
                end
            end
            // result RAM answers one cycle after res_raddr is registered
            if (rd_p2) bus_dout <= rd_sel ? res_rdata[15:8] : res_rdata[7:0];
            if (start) rptr <= '0;
        end
    end

    assign op_raddr  = idx;
    assign alu_mode  = mode;
    assign alu_start = (state == S_ISSUE);
    assign alu_clr   = (state == S_ISSUE) && (idx == '0);
    assign res_we    = (state == S_STORE);
    assign res_waddr = idx;
    assign res_wdata = res_q;

endmodule

// File: tb/tb_simd_exec_ctrl.sv
// Bench for simd_exec_ctrl: behavioural operand/result RAMs and ALU, scoreboarded reads and stores.
module tb_simd_exec_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          CS, WR, RD, CD, excute;
    logic [7:0]    bus_din, bus_dout;
    logic          op_we_a, op_we_b;
    logic [AW-1:0] op_waddr, op_raddr, res_waddr, res_raddr;
    logic [7:0]    op_wdata;
    logic [1:0]    alu_mode;
    logic          alu_start, alu_clr, alu_done, res_we, busy, done;
    logic [15:0]   alu_result, res_wdata, res_rdata;

    simd_exec_ctrl #(.ADDR_W(AW), .ALU_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .CS(CS), .WR(WR), .RD(RD), .CD(CD), .excute(excute),
        .bus_din(bus_din), .bus_dout(bus_dout), .op_we_a(op_we_a), .op_we_b(op_we_b),
        .op_waddr(op_waddr), .op_wdata(op_wdata), .op_raddr(op_raddr), .alu_mode(alu_mode),
        .alu_start(alu_start), .alu_clr(alu_clr), .alu_done(alu_done), .alu_result(alu_result),
        .res_we(res_we), .res_waddr(res_waddr), .res_wdata(res_wdata), .res_raddr(res_raddr),
        .res_rdata(res_rdata), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // behavioural RAMs with one-cycle read latency
    logic [7:0]  mem_a [32];
    logic [7:0]  mem_b [32];
    logic [15:0] mem_r [32];
    logic [7:0]  a_rd, b_rd;
    always @(posedge clk) begin
        if (op_we_a) mem_a[op_waddr] <= op_wdata;
        if (op_we_b) mem_b[op_waddr] <= op_wdata;
        if (res_we)  mem_r[res_waddr] <= res_wdata;
        a_rd      <= mem_a[op_raddr];
        b_rd      <= mem_b[op_raddr];
        res_rdata <= mem_r[res_raddr];
    end

    // ALU model: add / mac / mul, answers alu_lat cycles after start unless hung
    int          alu_lat = 2;
    logic        alu_hang = 1'b0;
    int          cnt;
    logic [15:0] acc, pend, prod, acc_base;
    assign prod     = {8'd0, a_rd} * {8'd0, b_rd};
    assign acc_base = alu_clr ? 16'd0 : acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0; alu_done <= 1'b0; alu_result <= '0; acc <= '0; pend <= '0;
        end else begin
            alu_done <= 1'b0;
            if (alu_start && !alu_hang) begin
                cnt <= alu_lat;
                case (alu_mode)
                    2'd1: begin pend <= acc_base + prod; acc <= acc_base + prod; end
                    2'd2: pend <= prod;
                    default: pend <= {8'd0, a_rd} + {8'd0, b_rd};
                endcase
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    alu_done   <= 1'b1;
                    alu_result <= pend;
                end
            end
        end
    end

    // scoreboards
    logic [7:0]     rd_q  [$];
    logic [AW+15:0] res_exp [$];
    event           rd_ev;
    int op_a_cnt = 0, op_b_cnt = 0, res_cnt = 0, start_cnt = 0, clr_cnt = 0, busy_cyc = 0;

    initial forever begin
        logic [7:0] e;
        @(rd_ev);
        if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: actual=0x%0h required=none", bus_dout);
        end else begin
            e = rd_q.pop_front();
            chk("rd_byte", 32'(bus_dout), 32'(e));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (op_we_a)   op_a_cnt++;
            if (op_we_b)   op_b_cnt++;
            if (busy)      busy_cyc++;
            if (alu_start) start_cnt++;
            if (alu_clr)   clr_cnt++;
            if (res_we) begin
                logic [AW+15:0] e;
                res_cnt++;
                if (res_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL res_unexpected: actual idx=%0d data=0x%0h required=none", res_waddr, res_wdata);
                end else begin
                    e = res_exp.pop_front();
                    chk("res_idx", 32'(res_waddr), 32'(e[AW+15:16]));
                    chk("res_dat", 32'(res_wdata), 32'(e[15:0]));
                end
            end
        end
    end

    task automatic hwrite(input logic cd, input logic [7:0] d);
        @(negedge clk);
        CS = 1'b1; CD = cd; bus_din = d; WR = 1'b1;
        repeat (4) @(negedge clk);
        WR = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic hread(input logic cd, input logic [7:0] exp);
        @(negedge clk);
        rd_q.push_back(exp);
        CS = 1'b1; CD = cd; RD = 1'b1;
        repeat (6) @(negedge clk);
        -> rd_ev;
        RD = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_ex();
        @(negedge clk);
        excute = 1'b1;
        repeat (4) @(negedge clk);
        excute = 1'b0;
    endtask

    task automatic start_run();
        pulse_ex();
        chk("busy_rise", 32'(busy), 32'h1);
    endtask

    task automatic finish_run(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_end_busy_done", 32'({busy, done}), 32'h1);
    endtask

    task automatic push_res(input int i, input logic [15:0] v);
        logic [AW-1:0] ix;
        ix = AW'(i);
        res_exp.push_back({ix, v});
    endtask

    initial begin
        int n, r0;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r0;
        CS = 1'b0; WR = 1'b0; RD = 1'b0; CD = 1'b0; excute = 1'b0; bus_din = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus_dout", 32'(bus_dout), 32'h0);
        chk("rst_busy_done", 32'({busy, done}), 32'h0);
        chk("rst_op_we", 32'({op_we_a, op_we_b}), 32'h0);
        chk("rst_alu_start_clr", 32'({alu_start, alu_clr}), 32'h0);
        chk("rst_res_we", 32'(res_we), 32'h0);
        chk("rst_addrs", 32'({op_raddr, res_raddr, res_waddr}), 32'h0);
        chk("rst_mode", 32'(alu_mode), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        hread(1'b1, 8'h00);

        // len=3, mode=add, A=2,3,4, B=5,6,7
        hwrite(1'b1, 8'd65); hwrite(1'b0, 8'd3);
        hwrite(1'b1, 8'd64); hwrite(1'b0, 8'd0);
        hwrite(1'b1, 8'd0);  hwrite(1'b0, 8'd2); hwrite(1'b0, 8'd3); hwrite(1'b0, 8'd4);
        hwrite(1'b1, 8'd32); hwrite(1'b0, 8'd5); hwrite(1'b0, 8'd6); hwrite(1'b0, 8'd7);
        chk("op_a_pulses", 32'(op_a_cnt), 32'd3);
        chk("op_b_pulses", 32'(op_b_cnt), 32'd3);

        // slow ALU keeps the run busy while host traffic is attempted
        alu_lat = 20;
        push_res(0, 16'd7); push_res(1, 16'd9); push_res(2, 16'd11);
        start_run();
        hread(1'b1, 8'h80);
        hread(1'b0, 8'h80);
        hwrite(1'b0, 8'hAA);
        pulse_ex();
        chk("still_busy", 32'(busy), 32'h1);
        chk("busy_write_dropped", 32'(op_a_cnt + op_b_cnt), 32'd6);
        finish_run(500);
        repeat (10) @(negedge clk);
        chk("no_restart", 32'(busy), 32'h0);
        chk("res_count_add", 32'(res_cnt), 32'd3);
        hread(1'b1, 8'h40);
        hread(1'b0, 8'h07); hread(1'b0, 8'h00); hread(1'b0, 8'h09);
        hread(1'b0, 8'h00); hread(1'b0, 8'h0B); hread(1'b0, 8'h00);
        hread(1'b0, 8'h07);

        // mul
        alu_lat = 2;
        hwrite(1'b1, 8'd64); hwrite(1'b0, 8'd2);
        push_res(0, 16'd10); push_res(1, 16'd18); push_res(2, 16'd28);
        start_run();
        finish_run(200);
        hread(1'b0, 8'h0A); hread(1'b0, 8'h00); hread(1'b0, 8'h12);
        hread(1'b0, 8'h00); hread(1'b0, 8'h1C); hread(1'b0, 8'h00);

        // mac
        hwrite(1'b0, 8'd1);
        start_cnt = 0; clr_cnt = 0;
        push_res(0, 16'd10); push_res(1, 16'd28); push_res(2, 16'd56);
        start_run();
        finish_run(200);
        chk("mac_starts", 32'(start_cnt), 32'd3);
        chk("mac_clr_once", 32'(clr_cnt), 32'd1);
        hread(1'b0, 8'h0A); hread(1'b0, 8'h00); hread(1'b0, 8'h1C);
        hread(1'b0, 8'h00); hread(1'b0, 8'h38); hread(1'b0, 8'h00);

        // hung ALU: FETCH + ISSUE + 255 WAIT + FIN
        alu_hang = 1'b1;
        r0 = res_cnt;
        @(negedge clk) busy_cyc = 0;
        start_run();
        finish_run(400);
        chk("timeout_busy_cycles", 32'(busy_cyc), 32'd258);
        chk("timeout_no_res_we", 32'(res_cnt), 32'(r0));
        hread(1'b1, 8'h60);
        alu_hang = 1'b0;

        // full bank: A[i]=i, B[i]=2i+1, len=0, add -> 3i+1
        hwrite(1'b1, 8'd0);
        for (int i = 0; i < 32; i++) hwrite(1'b0, 8'(i));
        hwrite(1'b1, 8'd32);
        for (int i = 0; i < 32; i++) hwrite(1'b0, 8'(2 * i + 1));
        hwrite(1'b1, 8'd65); hwrite(1'b0, 8'd0);
        hwrite(1'b1, 8'd64); hwrite(1'b0, 8'd0);
        r0 = res_cnt;
        for (int i = 0; i < 32; i++) push_res(i, 16'(3 * i + 1));
        start_run();
        finish_run(800);
        chk("full_res_count", 32'(res_cnt - r0), 32'd32);
        for (int i = 0; i < 32; i++) begin
            hread(1'b0, 8'(3 * i + 1));
            hread(1'b0, 8'h00);
        end
        hread(1'b0, 8'h01);

        // reset during WAIT of element 1 (mode=mul, len=3 beforehand)
        hwrite(1'b1, 8'd64); hwrite(1'b0, 8'd2);
        hwrite(1'b1, 8'd65); hwrite(1'b0, 8'd3);
        alu_lat = 20;
        push_res(0, 16'd0);
        start_cnt = 0;
        start_run();
        n = 0;
        while (start_cnt < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reached_elem1", 32'(start_cnt), 32'd2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy_done", 32'({busy, done}), 32'h0);
        chk("midrst_bus_dout", 32'(bus_dout), 32'h0);
        chk("midrst_ctl", 32'({alu_start, res_we, op_raddr}), 32'h0);
        chk("midrst_mode", 32'(alu_mode), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        res_exp.delete();
        hread(1'b1, 8'h00);
        alu_lat = 2;
        r0 = res_cnt;
        for (int i = 0; i < 32; i++) push_res(i, 16'(3 * i + 1));
        start_run();
        finish_run(800);
        chk("post_rst_res_count", 32'(res_cnt - r0), 32'd32);
        hread(1'b0, 8'h01); hread(1'b0, 8'h00); hread(1'b0, 8'h04); hread(1'b0, 8'h00);

        repeat (5) @(negedge clk);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("res_queue_drained", 32'(res_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
